// File: rtl/reg_file_loader.sv
// rtl/reg_file_loader.sv - byte-stream to 32-bit register-file write master (optional LOADER_CHECKSUM_EN trailer check)
module reg_file_loader #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 5
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] word_cnt_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              RegWrite_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [31:0]       RDdata_o,
  output logic [3:0]        is_pos_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PACK,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_e;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] left_q, left_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [3:0]        pos_q, pos_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hs;
  logic [ADDR_W:0]   range_end;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  // End of the requested range, one bit wider so it never wraps
  assign range_end = {1'b0, base_addr_i} + {1'b0, word_cnt_i};

  // State and output registers; every output comes straight from a flop
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      left_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      wr_q       <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      pos_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      wr_q       <= wr_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      pos_q      <= pos_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up with it
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    left_d     = left_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    err_d      = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    hs = byte_valid_i && ready_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d     = base_addr_i;
          left_d     = word_cnt_i;
          byte_cnt_d = '0;
          word_d     = '0;
          err_d      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
          if (word_cnt_i == '0) begin
            state_d = S_DONE;
          end else if (range_end > LIMIT) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_PACK;
          end
        end
      end
      S_PACK: begin
        if (hs) begin
          word_d     = {word_q[23:0], byte_data_i};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = sum_q + byte_data_i;
`endif
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        left_d     = left_q - ADDR_W'(1);
        byte_cnt_d = '0;
        if (left_d == '0) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_PACK;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (hs) begin
          if (byte_data_i != sum_q) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_PACK);
`ifdef LOADER_CHECKSUM_EN
    if (state_d == S_CHK) ready_d = 1'b1;
`endif
    wr_d      = (state_d == S_WRITE);
    rd_addr_d = wr_d ? addr_d : '0;
    rd_data_d = wr_d ? word_d : '0;
    pos_d     = wr_d ? ~{word_d[31], word_d[23], word_d[15], word_d[7]} : 4'b0000;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  assign byte_ready_o = ready_q;
  assign RegWrite_o   = wr_q;
  assign RDaddr_o     = rd_addr_q;
  assign RDdata_o     = rd_data_q;
  assign is_pos_o     = pos_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_reg_file_loader.sv
// tb/tb_reg_file_loader.sv - self-checking bench for reg_file_loader
module tb_reg_file_loader;
  localparam int ADDR_W = 5;

  logic              clk_i = 1'b0;
  logic              reset_n;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W-1:0] word_cnt_i;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              RegWrite_o;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [31:0]       RDdata_o;
  logic [3:0]        is_pos_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  always #5 clk_i = ~clk_i;

  reg_file_loader #(.NUM_REGS(16), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .reset_n(reset_n), .start_i(start_i),
    .base_addr_i(base_addr_i), .word_cnt_i(word_cnt_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready_o), .RegWrite_o(RegWrite_o),
    .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o), .is_pos_o(is_pos_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct {
    logic [4:0]  base;
    logic [4:0]  cnt;
    logic [63:0] bytes;
    logic        exp_err;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [3:0]  p0;
    logic [3:0]  p1;
    logic        gap;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  pos;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard side: every write strobe is matched against the next queued expectation
  always @(negedge clk_i) begin
    if (reset_n) begin
      if (done_o) done_seen++;
      if (RegWrite_o) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {RDaddr_o, RDdata_o}, 64'h0);
        end else begin
          mon_e = sb.pop_front();
          check("wr_addr", RDaddr_o, mon_e.addr);
          check("wr_data", RDdata_o, mon_e.data);
          check("wr_is_pos", is_pos_o, mon_e.pos);
        end
      end else begin
        check("idle_write_bus_zero", {RDaddr_o, RDdata_o, is_pos_o}, 64'h0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    while (!byte_ready_o && g < 20) begin
      @(negedge clk_i);
      g++;
    end
    check("byte_handshake_timeout", (g < 20), 1);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic start_load(input logic [4:0] base, input logic [4:0] cnt);
    @(negedge clk_i);
    base_addr_i = base;
    word_cnt_i  = cnt;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (busy_o && g < 20) begin
      @(negedge clk_i);
      g++;
    end
    check({tag, "_idle_timeout"}, busy_o, 0);
    @(negedge clk_i);
  endtask

  task automatic do_load(input vec_t v, input string tag);
    int         d0;
    int         nb;
    logic [7:0] b;
    logic [7:0] sum;
    if (!v.exp_err && v.cnt > 0) begin
      sb.push_back('{addr: v.base, data: v.w0, pos: v.p0});
      if (v.cnt > 1) sb.push_back('{addr: v.base + 5'd1, data: v.w1, pos: v.p1});
    end
    nb  = (v.exp_err || v.cnt == 0) ? 0 : int'(v.cnt) * 4;
    sum = 8'h00;
    d0  = done_seen;
    start_load(v.base, v.cnt);
    for (int k = 0; k < nb; k++) begin
      b = v.bytes[63-8*k -: 8];
      sum = sum + b;
      send_byte(b);
      if (v.gap) begin
        if (k == 5) begin
          base_addr_i = 5'd0;
          word_cnt_i  = 5'd1;
          start_i     = 1'b1;
        end
        @(negedge clk_i);
        start_i = 1'b0;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (nb > 0) send_byte(sum);
`endif
    wait_idle(tag);
    check({tag, "_done_pulses"}, done_seen - d0, 1);
    check({tag, "_err"}, err_o, v.exp_err);
    check({tag, "_writes_drained"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5'd12, 5'd2, 64'h1743030f08785b1f, 1'b0, 32'h1743030f, 32'h08785b1f, 4'b1111, 4'b1111, 1'b0};
    vecs[1] = '{5'd3,  5'd1, 64'hff7f000000000000, 1'b0, 32'hff7f0000, 32'h0, 4'b0111, 4'b0, 1'b0};
    vecs[2] = '{5'd14, 5'd3, 64'h0, 1'b1, 32'h0, 32'h0, 4'b0, 4'b0, 1'b0};
    vecs[3] = '{5'd0,  5'd1, 64'h8000800100000000, 1'b0, 32'h80008001, 32'h0, 4'b0101, 4'b0, 1'b0};
    vecs[4] = '{5'd15, 5'd1, 64'ha55ac33c00000000, 1'b0, 32'ha55ac33c, 32'h0, 4'b0101, 4'b0, 1'b0};
    vecs[5] = '{5'd15, 5'd2, 64'h0, 1'b1, 32'h0, 32'h0, 4'b0, 4'b0, 1'b0};
    vecs[6] = '{5'd0,  5'd0, 64'h0, 1'b0, 32'h0, 32'h0, 4'b0, 4'b0, 1'b0};
    vecs[7] = '{5'd12, 5'd2, 64'h1743030f08785b1f, 1'b0, 32'h1743030f, 32'h08785b1f, 4'b1111, 4'b1111, 1'b1};

    reset_n      = 1'b0;
    start_i      = 1'b0;
    base_addr_i  = '0;
    word_cnt_i   = '0;
    byte_valid_i = 1'b0;
    byte_data_i  = '0;
    repeat (3) @(negedge clk_i);
    check("reset_outputs",
          {byte_ready_o, RegWrite_o, RDaddr_o, RDdata_o, is_pos_o, busy_o, done_o, err_o}, 64'h0);
    reset_n = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 8; i++) do_load(vecs[i], $sformatf("vec%0d", i));

    // Write strobe lands in the cycle right after the 4th handshake and lasts one cycle
    sb.push_back('{addr: 5'd7, data: 32'hff7f0000, pos: 4'b0111});
    start_load(5'd7, 5'd1);
    send_byte(8'hff);
    send_byte(8'h7f);
    send_byte(8'h00);
    send_byte(8'h00);
    check("write_after_4th_hs", {RegWrite_o, byte_ready_o}, 2'b10);
    @(negedge clk_i);
    check("write_one_cycle", RegWrite_o, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h7e);
`endif
    wait_idle("timing");

    // Out-of-range request aborts straight to DONE without writes, next start clears err
    start_load(5'd14, 5'd3);
    check("range_err_done", {done_o, err_o, RegWrite_o, busy_o}, 4'b1101);
    @(negedge clk_i);
    check("range_err_after", {done_o, err_o, busy_o}, 3'b010);
    do_load(vecs[3], "err_clear");

    // Reset in the middle of a word discards the partial bytes
    start_load(5'd4, 5'd1);
    send_byte(8'haa);
    send_byte(8'hbb);
    reset_n = 1'b0;
    @(negedge clk_i);
    check("midload_reset_outputs",
          {byte_ready_o, RegWrite_o, RDaddr_o, RDdata_o, is_pos_o, busy_o, done_o, err_o}, 64'h0);
    reset_n = 1'b1;
    @(negedge clk_i);
    do_load('{5'd4, 5'd1, 64'h0101010100000000, 1'b0, 32'h01010101, 32'h0, 4'b1111, 4'b0, 1'b0}, "post_reset");

`ifdef LOADER_CHECKSUM_EN
    // Correct and wrong checksum trailers; the write happens either way
    sb.push_back('{addr: 5'd2, data: 32'h01020304, pos: 4'b1111});
    start_load(5'd2, 5'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0a);
    wait_idle("chk_good");
    check("chk_good_err", err_o, 0);
    sb.push_back('{addr: 5'd2, data: 32'h01020304, pos: 4'b1111});
    start_load(5'd2, 5'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0b);
    wait_idle("chk_bad");
    check("chk_bad_err", err_o, 1);
    check("chk_bad_write_kept", sb.size(), 0);
`else
    // Without the checksum no trailing byte is taken after the last word
    sb.push_back('{addr: 5'd2, data: 32'h01020304, pos: 4'b1111});
    start_load(5'd2, 5'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h0a;
    for (int c = 0; c < 4; c++) begin
      check("no_trailer_ready", byte_ready_o, 0);
      @(negedge clk_i);
    end
    byte_valid_i = 1'b0;
    wait_idle("no_chk");
    check("no_chk_err", err_o, 0);
`endif

    repeat (2) @(negedge clk_i);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
